// File: rtl/ysyx_23060072_lsu_wb_pkg.sv
// Shared definitions for the LSU/write-back stage: FSM states, access size codes, x0 index.
package ysyx_23060072_lsu_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/ysyx_23060072_lsu_align.sv
// Combinational lane logic: load byte/half extraction with extension, store strobes and replication.
module ysyx_23060072_lsu_align
  import ysyx_23060072_lsu_wb_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = rdata[{lane[1], 4'b0000} +: 16];
    ldata    = rdata;
    wdata    = sdata;
    wstrb    = 4'b1111;
    unique case (size)
      SZ_B: begin
        ldata = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        wdata = {4{sdata[7:0]}};
        wstrb = 4'b0001 << lane;
      end
      SZ_H: begin
        ldata = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        wdata = {2{sdata[15:0]}};
        wstrb = 4'b0011 << {lane[1], 1'b0};
      end
      // size 11 is an alias for word
      SZ_W, 2'b11: begin
        ldata = rdata;
        wdata = sdata;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060072_lsu_wb.sv
// RV32E load/store + write-back stage driving the register-file write port.
// Optional misaligned-access trap enabled by YSYX_23060072_MISALIGN_TRAP_EN.
module ysyx_23060072_lsu_wb
  import ysyx_23060072_lsu_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_rd_we_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic        ex_is_load_i,
  input  logic        ex_is_store_i,
  input  logic [1:0]  ex_size_i,
  input  logic        ex_unsigned_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  wb_reg_addr_o,
  output logic        wb_flag_o,
  output logic [31:0] wb_wdata_o,
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        bus_err_o
);

  localparam logic [CNT_W-1:0] CntLast =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic             rd_we_q;
  logic             load_q;
  logic [31:0]      addr_q;
  logic [31:0]      sdata_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [4:0]       wb_addr_q;
  logic [31:0]      wb_data_q;
  logic             wb_flag_q;
  logic             bus_err_q;

  logic [31:0] ld_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        mem_op;
  logic        misaligned;
  logic        wd_fire;

  assign mem_op  = ex_is_load_i | ex_is_store_i;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

`ifdef YSYX_23060072_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misaligned = ((ex_size_i == SZ_H) && ex_result_i[0]) ||
                      (ex_size_i[1] && (ex_result_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  ysyx_23060072_lsu_align u_align (
    .lane  (addr_q[1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .rdata (mem_rdata_i),
    .sdata (sdata_q),
    .ldata (ld_data),
    .wdata (st_wdata),
    .wstrb (st_wstrb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= '0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_flag_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      wb_flag_q <= 1'b0;
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (ex_valid_i) begin
            if (mem_op && misaligned) begin
`ifdef YSYX_23060072_MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
            end else if (mem_op) begin
              rd_q    <= ex_rd_i;
              rd_we_q <= ex_rd_we_i;
              load_q  <= ex_is_load_i;
              addr_q  <= ex_result_i;
              sdata_q <= ex_store_data_i;
              size_q  <= ex_size_i;
              uns_q   <= ex_unsigned_i;
              cnt_q   <= '0;
              state_q <= StReq;
            end else if (ex_rd_we_i && (ex_rd_i != ZERO_REG)) begin
              wb_flag_q <= 1'b1;
              wb_addr_q <= ex_rd_i;
              wb_data_q <= ex_result_i;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_gnt_i) begin
            state_q <= load_q ? StWait : StIdle;
          end else if (wd_fire) begin
            bus_err_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rvalid_i) begin
            state_q <= StIdle;
            if (rd_we_q && (rd_q != ZERO_REG)) begin
              wb_flag_q <= 1'b1;
              wb_addr_q <= rd_q;
              wb_data_q <= ld_data;
            end
          end else if (wd_fire) begin
            bus_err_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs are gated by state so they are zero whenever no request is live.
  assign ex_ready_o    = (state_q == StIdle);
  assign mem_req_o     = (state_q == StReq);
  assign mem_we_o      = mem_req_o & ~load_q;
  assign mem_addr_o    = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata_o   = mem_we_o ? st_wdata : 32'd0;
  assign mem_wstrb_o   = mem_we_o ? st_wstrb : 4'd0;
  assign wb_reg_addr_o = wb_addr_q;
  assign wb_flag_o     = wb_flag_q;
  assign wb_wdata_o    = wb_data_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: doc/ysyx_23060072_lsu_wb.md
Name: ysyx_23060072_lsu_wb

Overview:
Load/store and write-back stage of the 3-stage RV32E pipeline. Sits directly upstream of the register file.
- Accepts one instruction per handshake from EX.
- Issues data-memory requests for loads and stores.
- Aligns and extends load data.
- Drives the single register-file write port: wb_reg_addr_o, wb_flag_o, wb_wdata_o. The register file uses these same-cycle for its bypass.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed between request issue and the gnt/rvalid that completes it; 0 disables the watchdog.
CNT_W, 8, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid_i  in  1  EX presents an instruction
ex_ready_o  out  1  stage can accept (high only in IDLE)
ex_rd_i  in  5  destination register
ex_rd_we_i  in  1  instruction writes rd
ex_result_i  in  32  ALU result, or effective address for loads/stores
ex_store_data_i  in  32  rs2 value for stores
ex_is_load_i  in  1  load
ex_is_store_i  in  1  store (exclusive with load)
ex_size_i  in  2  00 byte, 01 half, 10 word
ex_unsigned_i  in  1  zero-extend load (LBU/LHU)
mem_req_o  out  1  request valid
mem_we_o  out  1  write request
mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  out  32  lane-replicated store data
mem_wstrb_o  out  4  byte strobes
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data
wb_reg_addr_o  out  5  write-back register address
wb_flag_o  out  1  write-back enable, one-cycle pulse
wb_wdata_o  out  32  write-back data
bus_err_o  out  1  sticky watchdog timeout flag

Behaviour:
- Reset values: all outputs 0, except ex_ready_o=1. State is IDLE; the watchdog counter is 0.
- Accept condition: ex_valid_i & ex_ready_o at a rising edge.
- States and transitions:
  - IDLE, accept of a non-memory op: latch rd/result. Next cycle wb_flag_o=ex_rd_we_i & (rd!=0) for exactly one cycle. Stay in IDLE, so back-to-back ALU ops run at 1 per cycle.
  - IDLE, accept of a load/store: latch op and address, go to REQ.
  - REQ: mem_req_o=1 with stable addr/we/wdata/wstrb until mem_gnt_i.
    - Store on gnt: go to IDLE, no write-back.
    - Load on gnt: go to WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i, register the extracted data and go to IDLE. wb_flag_o pulses the next cycle with wb_wdata_o = loaded value.
  - mem_rvalid_i outside WAIT is ignored.
- Load extraction, with lane = addr[1:0]:
  - Byte: mem_rdata_i[8*lane+:8].
  - Half: mem_rdata_i[16*addr[1]+:16].
  - Extension: sign-extend unless ex_unsigned_i.
- Store lanes:
  - Byte: wstrb = 0001<<lane, data replicated 4x.
  - Half: wstrb = 0011<<(2*addr[1]), data replicated 2x.
  - Word: wstrb = 1111.
- Minimum latencies:
  - Load: accept → REQ (1) → gnt → rvalid → wb_flag; 3 cycles with same-cycle gnt and next-cycle rvalid.
  - Store: 1 cycle after gnt back to ready.
- x0: wb_flag_o never asserted with wb_reg_addr_o==0. wb_reg_addr_o/wb_wdata_o hold their last value when wb_flag_o=0.
- Watchdog:
  - Counter clears on entering REQ and increments in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES (nonzero): set bus_err_o (sticky until reset), drop mem_req_o, return to IDLE with no write-back.
- Reset mid-transaction: immediate return to IDLE. mem_req_o and wb_flag_o are deasserted asynchronously. A late rvalid after reset is ignored.
- ex_size_i=11 is treated as word.

Optional Feature:
Macro YSYX_23060072_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no memory request and performs no write-back.
  - Adds port misalign_o (out, 1). It pulses 1 cycle after accept; state stays IDLE.
- Undefined: the low address bits beyond the lane select are ignored, and the access proceeds as specified above.

Decomposition:
- Shared define package:
  - State encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
  - Size codes (SZ_B/SZ_H/SZ_W).
  - Constant ZERO_REG=5'd0.
- One sub-module, ysyx_23060072_lsu_align. It is purely combinational: load extraction/extension and store strobe/replication.

Test Plan:
- ALU op rd=5, result 0x1234_5678 → one cycle later wb_flag_o=1, wb_reg_addr_o=5, wb_wdata_o=0x12345678. Next cycle wb_flag_o=0.
- LB rd=3 addr 0x103, gnt immediate, rdata 0x80FF_0000 next cycle → wb_wdata_o=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH addr 0x202 data 0xABCD, gnt after 4 cycles → mem_req_o held 5 cycles, addr 0x200, wstrb 1100, wdata 0xABCDABCD. No wb_flag_o.
- ALU op with rd=0 and ex_rd_we_i=1 → wb_flag_o stays 0.
- Load with gnt but no rvalid, TIMEOUT_CYCLES=8 → bus_err_o=1 after 8 cycles. ex_ready_o returns 1, no wb pulse.
- rst_n low while in WAIT, rvalid one cycle after release → state IDLE, wb_flag_o stays 0.
